ram_copy_engine: RTL and testbench

Word-copy DMA initiator that owns the single port of the processor's 32-bit x 4096-word data RAM, the negedge-clocked synchronous-read/write memory. Given a source address, destination address and word count, it reads each source word and writes it to the destination, one word per two clocks, with a start/busy/done control interface for the processor's memory-mapped control logic.

---
 rtl/ram_copy_engine.sv | 177 +++++++++++++++++
 tb/tb_ram_copy_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: word-copy DMA initiator owning the single port of the
// negedge-clocked data RAM. It alternates one read cycle and one write cycle
// per word, so a copy of N words takes 2N+1 cycles including the done pulse.
// All outputs are registered. Address and data only change on posedge, which
// gives the RAM half a cycle of setup before the negedge at which it acts.
module ram_copy_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 13
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] src_addr,
  input  logic [ADDRESS_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_WIDTH-1:0]     words_done,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [ADDRESS_WIDTH-1:0] r_src;
  logic [ADDRESS_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [LEN_WIDTH-1:0]     r_idx;

  logic [LEN_WIDTH-1:0]     w_idx_inc;
  logic                     w_last;
  logic [ADDRESS_WIDTH-1:0] w_src_next_addr;
  logic [ADDRESS_WIDTH-1:0] w_dst_cur_addr;

  logic [ADDRESS_WIDTH-1:0] w_src_nxt;
  logic [ADDRESS_WIDTH-1:0] w_dst_nxt;
  logic [LEN_WIDTH-1:0]     w_len_nxt;
  logic [LEN_WIDTH-1:0]     w_idx_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic [LEN_WIDTH-1:0]     w_words_done_nxt;
  logic                     w_wen_nxt;
  logic [ADDRESS_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0]    w_din_nxt;

  // Address arithmetic truncates to ADDRESS_WIDTH so both pointers wrap at the
  // top of the RAM. The source address for the next read is precomputed from
  // i+1 so it can be presented in the same posedge that ends the write.
  assign w_idx_inc       = r_idx + LEN_WIDTH'(1);
  assign w_last          = (w_idx_inc == r_len);
  assign w_src_next_addr = r_src + w_idx_inc[ADDRESS_WIDTH-1:0];
  assign w_dst_cur_addr  = r_dst + r_idx[ADDRESS_WIDTH-1:0];

  // State register; reset takes effect immediately, even mid-copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort beats completion of the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (length == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = w_last ? S_FIN : S_RD;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; flags are decoded from the next state so
  // that they are registered alongside it.
  always_comb begin
    w_src_nxt        = r_src;
    w_dst_nxt        = r_dst;
    w_len_nxt        = r_len;
    w_idx_nxt        = r_idx;
    w_words_done_nxt = words_done;
    w_addr_nxt       = mem_addr;
    w_din_nxt        = mem_dataIn;
    w_busy_nxt       = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
    w_done_nxt       = (w_state_nxt == S_FIN);
    w_wen_nxt        = (w_state_nxt == S_WR);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_nxt        = src_addr;
          w_dst_nxt        = dst_addr;
          w_len_nxt        = length;
          w_idx_nxt        = '0;
          w_words_done_nxt = '0;
          if (length != '0) begin
            w_addr_nxt = src_addr;
          end
        end
      end
      S_RD: begin
        // An aborted read is simply dropped: data and address stay put.
        if (!abort) begin
          w_din_nxt  = mem_dataOut;
          w_addr_nxt = w_dst_cur_addr;
        end
      end
      S_WR: begin
        // The write has already happened at the negedge, so it is counted
        // whether or not the copy continues.
        w_idx_nxt        = w_idx_inc;
        w_words_done_nxt = words_done + LEN_WIDTH'(1);
        if (!abort && !w_last) begin
          w_addr_nxt = w_src_next_addr;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and latched copy parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      mem_wEn    <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
    end else begin
      r_src      <= w_src_nxt;
      r_dst      <= w_dst_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
      words_done <= w_words_done_nxt;
      mem_wEn    <= w_wen_nxt;
      mem_addr   <= w_addr_nxt;
      mem_dataIn <= w_din_nxt;
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: a negedge-clocked RAM model, a write scoreboard
// fed from a shadow copy of memory, and directed copy scenarios.
module tb_ram_copy_engine;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_done;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  logic [DW-1:0] ram    [4096];
  logic [DW-1:0] shadow [4096];
  logic [AW+DW-1:0] sb_q[$];

  int checks = 0;
  int errors = 0;

  ram_copy_engine #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem_wEn    (mem_wEn),
    .mem_addr   (mem_addr),
    .mem_dataIn (mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RAM model: synchronous read and write on negedge; DUT writes are popped
  // from the scoreboard as they happen.
  always @(negedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_wEn) begin
      ram[mem_addr] <= mem_dataIn;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=0x%0h data=0x%0h expected none", mem_addr, mem_dataIn);
      end
      if (sb_q.size() != 0) begin
        check("write_addr_data", {8'h0, mem_addr, mem_dataIn[11:0]}, {8'h0, sb_q[0][AW+DW-1:DW], sb_q[0][11:0]});
        check("write_data", mem_dataIn, sb_q[0][DW-1:0]);
        void'(sb_q.pop_front());
      end
    end
    mem_dataOut <= ram[mem_addr];
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    shadow[a] = v;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Forward word-by-word copy on the shadow memory gives the expected writes.
  task automatic push_writes(input logic [AW-1:0] s, input logic [AW-1:0] d, input int nw);
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    for (int k = 0; k < nw; k++) begin
      sa = s + AW'(k);
      da = d + AW'(k);
      shadow[da] = shadow[sa];
      sb_q.push_back({da, shadow[da]});
    end
  endtask

  // Launch a copy at the next posedge (cycle 0) and observe cycles 1..2n+5.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                          input int abort_cyc, input int restart_cyc,
                          output int busy_cnt, output int done_cnt, output int done_cyc, output int wen_cnt);
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; wen_cnt = 0;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 2 * int'(n) + 5; cyc++) begin
      if (busy) busy_cnt++;
      if (mem_wEn) wen_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      abort = (cyc == abort_cyc);
      if (cyc == restart_cyc) begin
        start = 1'b1; src_addr = 12'h000; dst_addr = 12'h300; length = 13'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  int bc, dc, dcy, wc;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_done", words_done, 0);
    check("rst_wen", mem_wEn, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_dataIn, 0);
    reset_n = 1'b1;

    // Copy 4 words
    for (int k = 0; k < 4; k++) preload(12'h010 + AW'(k), 32'hA0 + k);
    for (int k = 0; k < 4; k++) preload(12'h100 + AW'(k), 32'h0);
    push_writes(12'h010, 12'h100, 4);
    run_copy(12'h010, 12'h100, 13'd4, 0, 0, bc, dc, dcy, wc);
    check("c4_busy_cycles", bc, 8);
    check("c4_done_cycle", dcy, 9);
    check("c4_done_width", dc, 1);
    check("c4_wen_cycles", wc, 4);
    check("c4_words_done", words_done, 4);
    check("c4_sb_empty", sb_q.size(), 0);
    for (int k = 0; k < 4; k++) begin
      check("c4_dst", ram[12'h100 + AW'(k)], 32'hA0 + k);
      check("c4_src_kept", ram[12'h010 + AW'(k)], 32'hA0 + k);
    end

    // Zero length
    run_copy(12'h010, 12'h100, 13'd0, 0, 0, bc, dc, dcy, wc);
    check("z_busy_cycles", bc, 0);
    check("z_done_cycle", dcy, 1);
    check("z_done_width", dc, 1);
    check("z_wen_cycles", wc, 0);
    check("z_words_done", words_done, 0);

    // Address wrap
    preload(12'hFFE, 32'd1); preload(12'hFFF, 32'd2);
    preload(12'h000, 32'd3); preload(12'h001, 32'd4);
    push_writes(12'hFFE, 12'h7FF, 4);
    run_copy(12'hFFE, 12'h7FF, 13'd4, 0, 0, bc, dc, dcy, wc);
    for (int k = 0; k < 4; k++) check("wrap_dst", ram[12'h7FF + AW'(k)], k + 1);
    check("wrap_sb_empty", sb_q.size(), 0);

    // Overlapping forward copy
    preload(12'h020, 32'h55);
    for (int k = 1; k < 4; k++) preload(12'h020 + AW'(k), 32'h0);
    push_writes(12'h020, 12'h021, 3);
    run_copy(12'h020, 12'h021, 13'd3, 0, 0, bc, dc, dcy, wc);
    for (int k = 1; k < 4; k++) check("ovl_dst", ram[12'h020 + AW'(k)], 32'h55);
    check("ovl_done_cycle", dcy, 7);

    // Abort during the write of word 2; start glitch while busy is ignored
    for (int k = 0; k < 10; k++) preload(12'h040 + AW'(k), 32'hB0 + k);
    for (int k = 0; k < 10; k++) preload(12'h200 + AW'(k), 32'h0);
    push_writes(12'h040, 12'h200, 3);
    run_copy(12'h040, 12'h200, 13'd10, 6, 3, bc, dc, dcy, wc);
    check("ab_busy_cycles", bc, 6);
    check("ab_no_done", dc, 0);
    check("ab_wen_cycles", wc, 3);
    check("ab_words_done", words_done, 3);
    check("ab_busy_now", busy, 0);
    check("ab_sb_empty", sb_q.size(), 0);
    check("ab_word2", ram[12'h202], 32'hB2);
    check("ab_word3", ram[12'h203], 32'h0);
    check("ab_glitch_dst", ram[12'h300] === 32'h0 || ram[12'h300] === 'x, 1);

    // Reset in the middle of the second write cycle
    for (int k = 0; k < 4; k++) preload(12'h060 + AW'(k), 32'hC0 + k);
    for (int k = 0; k < 4; k++) preload(12'h400 + AW'(k), 32'h0);
    push_writes(12'h060, 12'h400, 1);
    src_addr = 12'h060; dst_addr = 12'h400; length = 13'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rm_wen_before", mem_wEn, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rm_wen", mem_wEn, 0);
    check("rm_busy", busy, 0);
    check("rm_done", done, 0);
    check("rm_words_done", words_done, 0);
    check("rm_addr", mem_addr, 0);
    check("rm_din", mem_dataIn, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rm_sb_empty", sb_q.size(), 0);
    check("rm_word0", ram[12'h400], 32'hC0);
    check("rm_word1", ram[12'h401], 32'h0);
    check("rm_idle_busy", busy, 0);

    // Fresh copy after reset
    push_writes(12'h060, 12'h400, 4);
    run_copy(12'h060, 12'h400, 13'd4, 0, 0, bc, dc, dcy, wc);
    check("fr_done_cycle", dcy, 9);
    check("fr_words_done", words_done, 4);
    check("fr_sb_empty", sb_q.size(), 0);
    for (int k = 0; k < 4; k++) check("fr_dst", ram[12'h400 + AW'(k)], 32'hC0 + k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
